// File: rtl/timer_digits.sv
// MM:SS BCD stopwatch with an arming delay, pause/resume and clear.
// Optional `TIMER_SATURATE_EN: stop at 59:59 instead of wrapping to 00:00.
module timer_digits #(
  parameter int CLK_HZ      = 25000000,
  parameter int ARM_SECONDS = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  output logic [3:0] dig0,
  output logic [3:0] dig1,
  output logic [3:0] dig2,
  output logic [3:0] dig3,
  output logic [2:0] actual_state,
  output logic       sec_tick
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);
  localparam logic [3:0]    ARM_LOAD  = 4'(ARM_SECONDS);

  typedef enum logic [2:0] {
    S_INICIAL  = 3'b000,
    S_ESTABLE  = 3'b001,
    S_CONTANDO = 3'b010,
    S_DETENIDO = 3'b011
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [3:0]    arm_q, arm_d;
  logic [15:0]   digits_q, digits_d;
  logic          tick_q, tick_d;
  logic          sat_q, sat_d;
  logic          presc_wrap;

  // Packed as {min tens, min units, sec tens, sec units}; each digit clamps
  // back to 0 at or above its limit so a digit can never leave its range.
  function automatic logic [15:0] bcd_inc(input logic [15:0] d);
    logic [3:0] m10, m1, s10, s1;
    {m10, m1, s10, s1} = d;
    if (s1 >= 4'd9) begin
      s1 = 4'd0;
      if (s10 >= 4'd5) begin
        s10 = 4'd0;
        if (m1 >= 4'd9) begin
          m1 = 4'd0;
          if (m10 >= 4'd5) m10 = 4'd0;
          else             m10 = m10 + 4'd1;
        end else begin
          m1 = m1 + 4'd1;
        end
      end else begin
        s10 = s10 + 4'd1;
      end
    end else begin
      s1 = s1 + 4'd1;
    end
    return {m10, m1, s10, s1};
  endfunction

  assign presc_wrap = (presc_q == PRESC_MAX);

  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    arm_d    = arm_q;
    digits_d = digits_q;
    tick_d   = 1'b0;
    sat_d    = sat_q;
    if (clear) begin
      state_d  = S_INICIAL;
      presc_d  = '0;
      arm_d    = 4'd0;
      digits_d = 16'h0000;
      sat_d    = 1'b0;
    end else begin
      case (state_q)
        S_INICIAL: begin
          presc_d  = '0;
          digits_d = 16'h0000;
          sat_d    = 1'b0;
          if (start) begin
            state_d = S_ESTABLE;
            arm_d   = ARM_LOAD;
          end
        end
        S_ESTABLE: begin
          if (stop) begin
            state_d = S_INICIAL;
            presc_d = '0;
            arm_d   = 4'd0;
          end else begin
            presc_d = presc_wrap ? '0 : presc_q + PW'(1);
            if (presc_wrap) begin
              tick_d = 1'b1;
              if (arm_q <= 4'd1) begin
                arm_d   = 4'd0;
                state_d = S_CONTANDO;
              end else begin
                arm_d = arm_q - 4'd1;
              end
            end
          end
        end
        S_CONTANDO: begin
          // A tick landing on the stop edge is dropped and the prescaler
          // keeps its value, so the paused second resumes where it left off.
          if (stop) begin
            state_d = S_DETENIDO;
          end else begin
            presc_d = presc_wrap ? '0 : presc_q + PW'(1);
            if (presc_wrap) begin
              tick_d = 1'b1;
`ifdef TIMER_SATURATE_EN
              if (digits_q == 16'h5959) begin
                state_d = S_DETENIDO;
                sat_d   = 1'b1;
              end else begin
                digits_d = bcd_inc(digits_q);
              end
`else
              digits_d = bcd_inc(digits_q);
`endif
            end
          end
        end
        S_DETENIDO: begin
          if (start && !sat_q) state_d = S_CONTANDO;
        end
        default: begin
          state_d  = S_INICIAL;
          presc_d  = '0;
          arm_d    = 4'd0;
          digits_d = 16'h0000;
          sat_d    = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_INICIAL;
      presc_q  <= '0;
      arm_q    <= 4'd0;
      digits_q <= 16'h0000;
      tick_q   <= 1'b0;
      sat_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      arm_q    <= arm_d;
      digits_q <= digits_d;
      tick_q   <= tick_d;
      sat_q    <= sat_d;
    end
  end

  assign dig0         = digits_q[15:12];
  assign dig1         = digits_q[11:8];
  assign dig2         = digits_q[7:4];
  assign dig3         = digits_q[3:0];
  assign actual_state = state_q;
  assign sec_tick     = tick_q;

endmodule

// File: tb/tb_timer_digits.sv
// Scoreboard bench for timer_digits with CLK_HZ=4, ARM_SECONDS=2.
module tb_timer_digits;

  logic       clk = 1'b0;
  logic       rst_n, start, stop, clear;
  logic [3:0] dig0, dig1, dig2, dig3;
  logic [2:0] actual_state;
  logic       sec_tick;

  int n_checks = 0;
  int n_fail   = 0;
  int secs     = 0;
  logic [15:0] exp_q[$];

  timer_digits #(.CLK_HZ(4), .ARM_SECONDS(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .clear(clear),
    .dig0(dig0), .dig1(dig1), .dig2(dig2), .dig3(dig3),
    .actual_state(actual_state), .sec_tick(sec_tick)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] to_bcd(input int s);
    int m, ss;
    m  = (s / 60) % 60;
    ss = s % 60;
    return {4'(m / 10), 4'(m % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  function automatic logic [15:0] digs();
    return {dig0, dig1, dig2, dig3};
  endfunction

  // Advance one clock; inputs are driven and outputs sampled on negedge.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic pulse(input logic s, input logic p, input logic c);
    start = s; stop = p; clear = c;
    step();
    start = 1'b0; stop = 1'b0; clear = 1'b0;
  endtask

  // Waits (bounded) for sec_tick; cycles counts edges taken to see it.
  task automatic wait_tick(output int cycles, output bit got);
    got = 1'b0;
    cycles = 0;
    for (int i = 0; i < 12 && !got; i++) begin
      step();
      cycles++;
      if (sec_tick === 1'b1) got = 1'b1;
    end
  endtask

  // Counts one second: pushes the expected digits, then pops on the tick.
  task automatic count_one(input string name, output int cycles);
    bit got;
    logic [15:0] exp;
    secs++;
    exp_q.push_back(to_bcd(secs));
    wait_tick(cycles, got);
    exp = exp_q.pop_front();
    n_checks++;
    if (!got) begin
      n_fail++;
      $display("FAIL %s: no sec_tick within bound, expected digits %h", name, exp);
    end else if (digs() !== exp) begin
      n_fail++;
      $display("FAIL %s: digits %h, expected %h (secs=%0d)", name, digs(), exp, secs);
    end
  endtask

  task automatic arm_and_start();
    bit got;
    int c;
    pulse(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 20 && actual_state !== 3'b010; i++) step();
    secs = 0;
    c = 0;
    got = 1'b0;
  endtask

  task automatic test_reset();
    int seen;
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0;
    repeat (3) step();
    n_checks++;
    if (actual_state !== 3'b000 || digs() !== 16'h0000 || sec_tick !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hold: state=%b digits=%h tick=%b, expected 000/0000/0",
               actual_state, digs(), sec_tick);
    end
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (sec_tick !== 1'b0 || actual_state !== 3'b000 || digs() !== 16'h0000) seen++;
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL reset_idle: %0d idle cycles with activity, expected 0", seen);
    end
  endtask

  task automatic test_arm();
    int cyc, c;
    pulse(1'b1, 1'b0, 1'b0);
    n_checks++;
    if (actual_state !== 3'b001) begin
      n_fail++;
      $display("FAIL arm_enter: state=%b, expected 001", actual_state);
    end
    pulse(1'b1, 1'b0, 1'b0);
    cyc = 1;
    for (int i = 0; i < 20 && actual_state === 3'b001; i++) begin
      step();
      cyc++;
    end
    n_checks++;
    if (actual_state !== 3'b010 || cyc != 8) begin
      n_fail++;
      $display("FAIL arm_time: state=%b after %0d cycles, expected 010 after 8",
               actual_state, cyc);
    end
    secs = 0;
    for (int k = 0; k < 4; k++) begin
      count_one("count_first", c);
      n_checks++;
      if (c != 4) begin
        n_fail++;
        $display("FAIL tick_period: %0d cycles, expected 4", c);
      end
    end
  endtask

  task automatic test_stop_resume();
    int c, held;
    count_one("count_to_5", c);
    step();
    pulse(1'b0, 1'b1, 1'b0);
    n_checks++;
    if (actual_state !== 3'b011) begin
      n_fail++;
      $display("FAIL stop_enter: state=%b, expected 011", actual_state);
    end
    held = 0;
    for (int i = 0; i < 20; i++) begin
      if (i == 5) stop = 1'b1;
      step();
      stop = 1'b0;
      if (digs() !== 16'h0005 || sec_tick !== 1'b0 || actual_state !== 3'b011) held++;
    end
    n_checks++;
    if (held != 0) begin
      n_fail++;
      $display("FAIL stop_hold: %0d cycles changed while paused, expected 0", held);
    end
    pulse(1'b1, 1'b0, 1'b0);
    n_checks++;
    if (actual_state !== 3'b010) begin
      n_fail++;
      $display("FAIL resume: state=%b, expected 010", actual_state);
    end
    count_one("resume_tick", c);
    n_checks++;
    if (c != 3) begin
      n_fail++;
      $display("FAIL resume_remain: tick after %0d cycles, expected 3", c);
    end
    // Pause on the exact edge a tick would land: the tick must be dropped.
    step(); step();
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b1, 1'b0);
    n_checks++;
    if (actual_state !== 3'b011 || digs() !== 16'h0006 || sec_tick !== 1'b0) begin
      n_fail++;
      $display("FAIL stop_on_tick: state=%b digits=%h tick=%b, expected 011/0006/0",
               actual_state, digs(), sec_tick);
    end
    pulse(1'b1, 1'b0, 1'b0);
    count_one("resume_on_tick", c);
    n_checks++;
    if (c != 1) begin
      n_fail++;
      $display("FAIL resume_on_tick_remain: tick after %0d cycles, expected 1", c);
    end
  endtask

  task automatic test_priority();
    pulse(1'b1, 1'b1, 1'b1);
    n_checks++;
    if (actual_state !== 3'b000 || digs() !== 16'h0000) begin
      n_fail++;
      $display("FAIL prio_clear: state=%b digits=%h, expected 000/0000",
               actual_state, digs());
    end
    pulse(1'b1, 1'b0, 1'b0);
    repeat (3) step();
    pulse(1'b0, 1'b1, 1'b0);
    n_checks++;
    if (actual_state !== 3'b000) begin
      n_fail++;
      $display("FAIL arm_abort: state=%b, expected 000", actual_state);
    end
  endtask

  task automatic test_long_count();
    int c;
    arm_and_start();
    for (int k = 0; k < 3599; k++) count_one("long_count", c);
    n_checks++;
    if (digs() !== 16'h5959 || actual_state !== 3'b010) begin
      n_fail++;
      $display("FAIL reach_5959: digits=%h state=%b, expected 5959/010",
               digs(), actual_state);
    end
`ifdef TIMER_SATURATE_EN
    secs = 3599 - 1;
    count_one("saturate", c);
    n_checks++;
    if (actual_state !== 3'b011) begin
      n_fail++;
      $display("FAIL saturate_state: state=%b, expected 011", actual_state);
    end
    pulse(1'b1, 1'b0, 1'b0);
    step();
    n_checks++;
    if (actual_state !== 3'b011 || digs() !== 16'h5959) begin
      n_fail++;
      $display("FAIL saturate_start: state=%b digits=%h, expected 011/5959",
               actual_state, digs());
    end
`else
    count_one("wrap", c);
    n_checks++;
    if (actual_state !== 3'b010 || digs() !== 16'h0000) begin
      n_fail++;
      $display("FAIL wrap_state: state=%b digits=%h, expected 010/0000",
               actual_state, digs());
    end
`endif
    pulse(1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_reset_midcount();
    int c;
    arm_and_start();
    count_one("pre_reset", c);
    step();
    rst_n = 1'b0;
    step();
    n_checks++;
    if (actual_state !== 3'b000 || digs() !== 16'h0000 || sec_tick !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_midcount: state=%b digits=%h tick=%b, expected 000/0000/0",
               actual_state, digs(), sec_tick);
    end
    rst_n = 1'b1;
    pulse(1'b1, 1'b0, 1'b0);
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    n_checks++;
    if (actual_state !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_midarm: state=%b, expected 000", actual_state);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0;
    test_reset();
    test_arm();
    test_stop_resume();
    test_priority();
    test_long_count();
    test_reset_midcount();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
